// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial odd-parity framer: DATA_W bits LSB-first, then one parity bit.
// Optional PARITY_FRAME_ERR_INJECT_EN adds err_inject to invert a frame's parity bit.
module parity_frame_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef PARITY_FRAME_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              out,
  output logic              out_valid,
  output logic              frame_start,
  output logic              frame_last
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              par_q, par_d;

  logic accept;
  logic inject;
  logic load_par;

`ifdef PARITY_FRAME_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  // PARITY accepts too, which gives zero-gap back-to-back frames.
  assign in_ready = rst & ((state_q == StIdle) | (state_q == StParity));
  assign accept   = in_valid & in_ready;
  assign load_par = (~^in_data) ^ inject;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          shift_d = in_data;
          par_d   = load_par;
          cnt_d   = '0;
        end
      end
      StShift: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CntLast) begin
          state_d = StParity;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (accept) begin
          state_d = StShift;
          shift_d = in_data;
          par_d   = load_par;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Outputs decode registered state only, so they drop with the async reset.
  always_comb begin
    out         = 1'b0;
    out_valid   = 1'b0;
    frame_start = 1'b0;
    frame_last  = 1'b0;
    unique case (state_q)
      StShift: begin
        out         = shift_q[0];
        out_valid   = 1'b1;
        frame_start = (cnt_q == '0);
      end
      StParity: begin
        out        = par_q;
        out_valid  = 1'b1;
        frame_last = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Self-checking bench for parity_frame_serializer: vector table, corner sequences, random vs model.
module tb_parity_frame_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         err_inject;
  logic         out;
  logic         out_valid;
  logic         frame_start;
  logic         frame_last;

  int n_chk;
  int n_fail;

  parity_frame_serializer #(
    .DATA_W(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef PARITY_FRAME_ERR_INJECT_EN
    .err_inject (err_inject),
`endif
    .out        (out),
    .out_valid  (out_valid),
    .frame_start(frame_start),
    .frame_last (frame_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         par;
  } vec_t;

  vec_t vecs[8];
  bit   mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accept edge; checks all W+1 frame cycles.
  task automatic expect_frame(input logic [W-1:0] d, input logic p, input logic exp_chk,
                              input bit poke, input string nm);
    logic x;
    logic b;
    x = 1'b0;
    for (int c = 0; c <= W; c++) begin
      b = (c < W) ? d[c] : p;
      chk({nm, " out"}, out, b);
      chk({nm, " out_valid"}, out_valid, 1'b1);
      chk({nm, " frame_start"}, frame_start, (c == 0));
      chk({nm, " frame_last"}, frame_last, (c == W));
      chk({nm, " in_ready"}, in_ready, (c == W));
      x = x ^ out;
      if (poke && c == 2) begin
        in_valid = 1'b1;
        in_data  = ~d;
      end
      if (poke && c == 6) in_valid = 1'b0;
      step();
    end
    chk({nm, " checker"}, x, exp_chk);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    err_inject = 1'b0;

    vecs[0] = '{data: 8'hA5, par: 1'b1};
    vecs[1] = '{data: 8'h07, par: 1'b0};
    vecs[2] = '{data: 8'h00, par: 1'b1};
    vecs[3] = '{data: 8'hFF, par: 1'b1};
    vecs[4] = '{data: 8'h3C, par: 1'b1};
    vecs[5] = '{data: 8'h01, par: 1'b0};
    vecs[6] = '{data: 8'h80, par: 1'b0};
    vecs[7] = '{data: 8'h5A, par: 1'b1};

    #12;
    chk("reset out", out, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset frame_start", frame_start, 1'b0);
    chk("reset frame_last", frame_last, 1'b0);
    chk("reset in_ready", in_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("idle in_ready", in_ready, 1'b1);
    chk("idle out_valid", out_valid, 1'b0);

    // Single frames from the table.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      chk("vec pre in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      in_data  = $urandom;
      expect_frame(vecs[i].data, vecs[i].par, 1'b1, 1'b0, $sformatf("vec%0d", i));
      chk("vec idle out_valid", out_valid, 1'b0);
      chk("vec idle out", out, 1'b0);
    end

    // Back-to-back 0x00 then 0xFF with in_valid held.
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    in_data = 8'hFF;
    expect_frame(8'h00, 1'b1, 1'b1, 1'b0, "b2b first");
    in_valid = 1'b0;
    expect_frame(8'hFF, 1'b1, 1'b1, 1'b0, "b2b second");
    chk("b2b idle out_valid", out_valid, 1'b0);

    // Reset mid-frame during 0x3C.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("midrst bit", out, in_data[c]);
      step();
    end
    chk("midrst bit3", out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst out", out, 1'b0);
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst frame_start", frame_start, 1'b0);
    chk("midrst in_ready", in_ready, 1'b0);
    step();
    chk("midrst held out_valid", out_valid, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_valid = 1'b0;
    expect_frame(8'h01, 1'b0, 1'b1, 1'b0, "post rst");

    // Backpressure: new word offered mid-frame must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h96;
    step();
    in_valid = 1'b0;
    expect_frame(8'h96, 1'b1, 1'b1, 1'b1, "backpressure");
    chk("bp idle out_valid", out_valid, 1'b0);

`ifdef PARITY_FRAME_ERR_INJECT_EN
    in_valid   = 1'b1;
    in_data    = 8'hA5;
    err_inject = 1'b1;
    step();
    in_valid   = 1'b0;
    err_inject = 1'b0;
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, "err inject");
`endif

    // Random traffic against a bit-queue model of the line.
    mq.delete();
    for (int i = 0; i < 400; i++) begin
      logic mready;
      logic acc;
      logic errv;
      mready   = (mq.size() <= 1);
      in_valid = (i < 385) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = W'($urandom);
      errv     = 1'b0;
`ifdef PARITY_FRAME_ERR_INJECT_EN
      errv       = 1'($urandom_range(0, 1));
      err_inject = errv;
`endif
      chk("rand in_ready", in_ready, mready);
      acc = in_valid && mready;
      step();
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        for (int k = 0; k < W; k++) mq.push_back(in_data[k]);
        mq.push_back((~^in_data) ^ errv);
      end
      if (mq.size() > 0) begin
        chk("rand out_valid", out_valid, 1'b1);
        chk("rand out", out, mq[0]);
        chk("rand frame_start", frame_start, (mq.size() == W + 1));
        chk("rand frame_last", frame_last, (mq.size() == 1));
      end else begin
        chk("rand idle out_valid", out_valid, 1'b0);
        chk("rand idle out", out, 1'b0);
        chk("rand idle frame_start", frame_start, 1'b0);
        chk("rand idle frame_last", frame_last, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
